// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared memory/ALU datapath, flags illegal opcodes
// and memory timeouts, and counts retired instructions. Optional overflow trap via OVF_TRAP_EN.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_in,
    input  logic             zero,
    input  logic             overflow,
    input  logic             mem_ready,
    output logic [4:0]       state_out,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    typedef enum logic [4:0] {
        IDLE     = 5'd0,
        FETCH    = 5'd1,
        DECODE   = 5'd2,
        MEM_ADDR = 5'd3,
        MEM_RD   = 5'd4,
        MEM_WB   = 5'd5,
        MEM_WR   = 5'd6,
        R_EXEC   = 5'd7,
        R_WB     = 5'd8,
        BRANCH   = 5'd9,
        JUMP     = 5'd10,
        ILLEGAL  = 5'd11,
        MEM_ERR  = 5'd12,
        TRAP     = 5'd13
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [TO_W-1:0] to_cnt;
    logic            mem_wait;
    logic            timeout;
    logic            retire;
    logic [5:0]      opcode;

    assign opcode    = inst_in[31:26];
    assign state_out = 5'(state);

    // Only the opcode field matters here; zero is ANDed externally with pc_write_cond.
`ifdef OVF_TRAP_EN
    logic unused_bits;
    assign unused_bits = ^{zero, inst_in[25:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{zero, overflow, inst_in[25:0]};
`endif

    // Next-state decode; a timeout overrides everything unless the memory answers this cycle.
    always_comb begin
        state_n  = state;
        mem_wait = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
        timeout  = mem_wait && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
        case (state)
            IDLE:     state_n = FETCH;
            FETCH:    if (mem_ready) state_n = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:          state_n = R_EXEC;
                    OP_LW, OP_SW:  state_n = MEM_ADDR;
                    OP_BEQ:        state_n = BRANCH;
                    OP_J:          state_n = JUMP;
                    default:       state_n = ILLEGAL;
                endcase
            end
            MEM_ADDR: state_n = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) state_n = MEM_WB;
            MEM_WR:   if (mem_ready) state_n = FETCH;
`ifdef OVF_TRAP_EN
            R_EXEC:   state_n = overflow ? TRAP : R_WB;
`else
            R_EXEC:   state_n = R_WB;
`endif
            MEM_WB, R_WB, BRANCH, JUMP, ILLEGAL, TRAP: state_n = FETCH;
            MEM_ERR:  state_n = MEM_ERR;
            default:  state_n = IDLE;
        endcase
        if (timeout) state_n = MEM_ERR;
        retire = (state_n == FETCH) &&
                 ((state == MEM_WB) || (state == MEM_WR) || (state == R_WB) ||
                  (state == BRANCH) || (state == JUMP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            to_cnt  <= '0;
            retired <= '0;
            illegal <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state <= state_n;
            if ((state_n != state) || !mem_wait) to_cnt <= '0;
            else                                 to_cnt <= to_cnt + TO_W'(1);
            if (retire)               retired <= retired + CNT_W'(1);
            if (state_n == ILLEGAL)   illegal <= 1'b1;
            if (state_n == MEM_ERR)   mem_err <= 1'b1;
        end
    end

    // Datapath controls are a pure function of state (plus mem_ready for the fetch load).
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef OVF_TRAP_EN
            TRAP: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cycle table, timeout corner sequences, and a random run
// against an instruction-path reference model.
module tb_multicycle_ctrl;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 6;
`ifdef OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      inst_in = '0;
    logic             zero = 1'b0;
    logic             overflow = 1'b0;
    logic             mem_ready = 1'b1;
    logic [4:0]       state_out;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic             illegal, mem_err;
    logic [CNT_W-1:0] retired;
    logic [15:0]      ctrl;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .zero(zero), .overflow(overflow),
        .mem_ready(mem_ready), .state_out(state_out), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal), .mem_err(mem_err), .retired(retired)
    );

    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected control word for a state, straight from the per-state control list.
    function automatic logic [15:0] ctrl_of(input int s, input logic rdy);
        logic pw, pwc, io, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, io, mr, mw, irw, rd, m2r, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            6:  begin mw = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            10: begin pw = 1; psrc = 2'b10; end
            13: begin pw = 1; psrc = 2'b11; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc};
    endfunction

    // Reference model: each instruction is a list of states after FETCH; memory states hold
    // while the memory is not ready, and too long a wait lands in the terminal error state.
    int m_state, m_wait, m_ret;
    bit m_ill, m_merr;
    int m_path[$];

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_ret = 0; m_ill = 0; m_merr = 0;
        m_path.delete();
    endtask

    task automatic model_step(input bit rdy, input bit ovf, input logic [5:0] op);
        int prev;
        if (m_state == 0) begin m_state = 1; return; end
        if (m_state == 12) return;
        if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
            if (m_wait == int'(MEM_TIMEOUT) - 1) begin
                m_state = 12; m_merr = 1; m_wait = 0;
            end else m_wait++;
            return;
        end
        m_wait = 0;
        if (m_state == 1) begin
            case (op)
                6'h00:   m_path = '{2, 7, 8};
                6'h23:   m_path = '{2, 3, 4, 5};
                6'h2b:   m_path = '{2, 3, 6};
                6'h04:   m_path = '{2, 9};
                6'h02:   m_path = '{2, 10};
                default: m_path = '{2, 11};
            endcase
        end
        if (m_state == 7 && ovf && TRAP_EN) m_path = '{13};
        prev = m_state;
        if (m_path.size() == 0) begin
            if (prev == 5 || prev == 6 || prev == 8 || prev == 9 || prev == 10)
                m_ret = (m_ret + 1) % (1 << CNT_W);
            m_state = 1;
        end else begin
            m_state = m_path.pop_front();
            if (m_state == 11) m_ill = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       zr;
        logic       ovf;
        int         st;
        int         ret;
        logic       ill;
    } vec_t;

    function automatic vec_t v(input logic [5:0] op, input logic rdy, input logic zr,
                               input logic ovf, input int st, input int ret, input logic ill);
        vec_t r;
        r.op = op; r.rdy = rdy; r.zr = zr; r.ovf = ovf; r.st = st; r.ret = ret; r.ill = ill;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [5:0] op;
        bit rdy, ovf;

        // R-type, BEQ, J, illegal, LW with 3 stall cycles, then an overflowing R-type.
        tbl.push_back(v(6'h00, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(6'h00, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(6'h00, 1, 0, 0, 2, 0, 0));
        tbl.push_back(v(6'h00, 1, 0, 0, 7, 0, 0));
        tbl.push_back(v(6'h00, 1, 0, 0, 8, 0, 0));
        tbl.push_back(v(6'h04, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(6'h04, 1, 1, 0, 2, 1, 0));
        tbl.push_back(v(6'h04, 1, 1, 0, 9, 1, 0));
        tbl.push_back(v(6'h02, 1, 0, 0, 1, 2, 0));
        tbl.push_back(v(6'h02, 1, 0, 0, 2, 2, 0));
        tbl.push_back(v(6'h02, 1, 0, 0, 10, 2, 0));
        tbl.push_back(v(6'h3f, 1, 0, 0, 1, 3, 0));
        tbl.push_back(v(6'h3f, 1, 0, 0, 2, 3, 0));
        tbl.push_back(v(6'h3f, 1, 0, 0, 11, 3, 1));
        tbl.push_back(v(6'h23, 1, 0, 0, 1, 3, 1));
        tbl.push_back(v(6'h23, 1, 0, 0, 2, 3, 1));
        tbl.push_back(v(6'h23, 1, 0, 0, 3, 3, 1));
        tbl.push_back(v(6'h23, 0, 0, 0, 4, 3, 1));
        tbl.push_back(v(6'h23, 0, 0, 0, 4, 3, 1));
        tbl.push_back(v(6'h23, 0, 0, 0, 4, 3, 1));
        tbl.push_back(v(6'h23, 1, 0, 0, 4, 3, 1));
        tbl.push_back(v(6'h23, 1, 0, 0, 5, 3, 1));
        tbl.push_back(v(6'h00, 1, 0, 1, 1, 4, 1));
        tbl.push_back(v(6'h00, 1, 0, 1, 2, 4, 1));
        tbl.push_back(v(6'h00, 1, 0, 1, 7, 4, 1));
        tbl.push_back(v(6'h00, 1, 0, 1, TRAP_EN ? 13 : 8, 4, 1));
        tbl.push_back(v(6'h00, 1, 0, 1, 1, TRAP_EN ? 4 : 5, 1));

        do_reset();
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_flags", 32'({illegal, mem_err}), 32'd0);

        foreach (tbl[i]) begin
            inst_in   = {tbl[i].op, 26'h0c4820};
            mem_ready = tbl[i].rdy;
            zero      = tbl[i].zr;
            overflow  = tbl[i].ovf;
            #1;
            chk($sformatf("tbl%0d_state", i), 32'(state_out), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl), 32'(ctrl_of(tbl[i].st, tbl[i].rdy)));
            chk($sformatf("tbl%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
            chk($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
            tick();
        end
        overflow = 1'b0;

        // Fetch with 15 wait cycles completes normally.
        do_reset();
        inst_in = 32'h0;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < int'(MEM_TIMEOUT) - 1; k++) begin
            chk("wait15_state", 32'(state_out), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("wait15_last_state", 32'(state_out), 32'd1);
        chk("wait15_ir_write", 32'(ir_write), 32'd1);
        tick();
        chk("wait15_decode", 32'(state_out), 32'd2);
        chk("wait15_no_err", 32'(mem_err), 32'd0);

        // Fetch with 16 wait cycles times out into the terminal error state.
        do_reset();
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
            chk("wait16_state", 32'(state_out), 32'd1);
            tick();
        end
        chk("timeout_state", 32'(state_out), 32'd12);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("timeout_hold", 32'(state_out), 32'd12);
        chk("timeout_mem_err", 32'(mem_err), 32'd1);
        chk("timeout_ctrl", 32'(ctrl), 32'd0);
        do_reset();
        chk("timeout_rst_state", 32'(state_out), 32'd0);
        chk("timeout_rst_err", 32'(mem_err), 32'd0);

        // Random run against the reference model, with periodic resets and one long stall.
        do_reset();
        model_reset();
        op = 6'h00;
        for (int c = 0; c < 4000; c++) begin
            if (c % 700 == 699) begin
                do_reset();
                model_reset();
            end
            if (m_state == 1) begin
                case ($urandom_range(0, 5))
                    0: op = 6'h00;
                    1: op = 6'h23;
                    2: op = 6'h2b;
                    3: op = 6'h04;
                    4: op = 6'h02;
                    default: op = 6'($urandom);
                endcase
            end
            rdy = (c >= 1500 && c < 1530) ? 1'b0 : ($urandom_range(0, 3) != 0);
            ovf = ($urandom_range(0, 2) == 0);
            inst_in   = {op, 26'($urandom)};
            mem_ready = rdy;
            overflow  = ovf;
            zero      = 1'($urandom);
            #1;
            chk("rnd_state", 32'(state_out), 32'(m_state));
            chk("rnd_ctrl", 32'(ctrl), 32'(ctrl_of(m_state, rdy)));
            chk("rnd_retired", 32'(retired), 32'(m_ret));
            chk("rnd_illegal", 32'(illegal), 32'(m_ill));
            chk("rnd_mem_err", 32'(mem_err), 32'(m_merr));
            model_step(rdy, ovf, op);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
